// File: rtl/pmc_ac_pkg.sv
// Shared constants and state type for the analog-configuration serializer.
package pmc_ac_pkg;

  localparam int unsigned PMC_AC_NUM_REGS  = 4;
  localparam int unsigned PMC_AC_REG_WIDTH = 32;
  localparam int unsigned PMC_AC_DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCLK_LO,
    ST_SCLK_HI,
    ST_LOAD,
    ST_DONE
  } pmc_ac_ser_state_t;

endpackage

// File: rtl/pmc_ac_clk_divider.sv
// Phase timer for the serial interface: down-counter that flags the last
// cycle of a phase. Reloaded by the sequencer at every phase change.
module pmc_ac_clk_divider
  import pmc_ac_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = PMC_AC_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 phase_end
);

  logic [DIV_WIDTH-1:0] cnt_q;

  // Count down to zero and hold there; a load restarts the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/pmc_ac_serializer.sv
// Snapshots the analog-config register bank on start and shifts it out
// MSB-first, REG_0 first, on ac_sclk/ac_sdata, then strobes ac_load.
module pmc_ac_serializer
  import pmc_ac_pkg::*;
#(
  parameter int unsigned NUM_REGS  = PMC_AC_NUM_REGS,
  parameter int unsigned REG_WIDTH = PMC_AC_REG_WIDTH,
  parameter int unsigned DIV_WIDTH = PMC_AC_DIV_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic [NUM_REGS*REG_WIDTH-1:0] regs,
  output logic                          busy,
  output logic                          done,
  output logic                          ac_sclk,
  output logic                          ac_sdata,
  output logic                          ac_load
);

  localparam int unsigned N     = NUM_REGS * REG_WIDTH;
  localparam int unsigned CNT_W = $clog2(N);

  pmc_ac_ser_state_t    state_q, state_d;
  logic [N-1:0]         shift_q, shift_d;
  logic [N-1:0]         snap;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_val;
  logic                 div_load;
  logic                 phase_end;
  logic                 busy_d, done_d, sclk_d, sdata_d, load_d;

  pmc_ac_clk_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .load_val (div_val),
    .phase_end(phase_end)
  );

  // Reorder the bank so the first bit to send (REG_0 MSB) sits at the top.
  always_comb begin
    snap = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      snap[N-1-k*REG_WIDTH -: REG_WIDTH] = regs[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ac_sclk   <= 1'b0;
      ac_sdata  <= 1'b0;
      ac_load   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      busy      <= busy_d;
      done      <= done_d;
      ac_sclk   <= sclk_d;
      ac_sdata  <= sdata_d;
      ac_load   <= load_d;
    end
  end

  // Next-state, datapath update and next-output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    div_load  = 1'b0;
    div_val   = div_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = snap;
          div_d     = clk_div;
          bit_cnt_d = '0;
          // Divider is primed straight from clk_div so the first low phase
          // already spans clk_div+1 cycles.
          div_load  = 1'b1;
          div_val   = clk_div;
          state_d   = ST_SCLK_LO;
        end
      end
      ST_SCLK_LO: begin
        if (phase_end) begin
          div_load = 1'b1;
          state_d  = ST_SCLK_HI;
        end
      end
      ST_SCLK_HI: begin
        if (phase_end) begin
          div_load = 1'b1;
          if (bit_cnt_q == CNT_W'(N - 1)) begin
            state_d = ST_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[N-2:0], 1'b0};
            state_d   = ST_SCLK_LO;
          end
        end
      end
      ST_LOAD: begin
        if (phase_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state into flops, so each pin is a
    // direct register output aligned with the state it belongs to.
    busy_d  = (state_d == ST_SCLK_LO) || (state_d == ST_SCLK_HI) || (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
    sclk_d  = (state_d == ST_SCLK_HI);
    load_d  = (state_d == ST_LOAD);
    sdata_d = ((state_d == ST_SCLK_LO) || (state_d == ST_SCLK_HI)) ? shift_d[N-1] : 1'b0;
  end

endmodule
